// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: access sizes, FSM states
// and the tag recording which requester owns an in-flight read.
package mem_arb_pkg;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd3;
    localparam logic [2:0] SZ_HU = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [2:0]        d_size;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_err;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_re;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_size, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_err, d_rvalid, d_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_size, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_err, d_rvalid, d_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane logic: store lane enables and replication, load
// extraction with sign/zero extension, and the misaligned/illegal-size flag.
module mem_lane_steer
    import mem_arb_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  we_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    input  logic [2:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    always_comb begin
        we_o       = 4'b0000;
        wdata_o    = 32'h0;
        misalign_o = 1'b1;
        case (size_i)
            SZ_B, SZ_BU: begin
                we_o       = 4'b0001 << off_i;
                wdata_o    = {4{wdata_i[7:0]}};
                misalign_o = 1'b0;
            end
            SZ_H, SZ_HU: begin
                we_o       = 4'b0011 << off_i;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = off_i[0];
            end
            SZ_W: begin
                we_o       = 4'b1111;
                wdata_o    = wdata_i;
                misalign_o = (off_i != 2'b00);
            end
            default: ;
        endcase
    end

    // Loads only reach here aligned, so a halfword never straddles the word.
    always_comb begin
        shifted   = ld_word_i >> {ld_off_i, 3'b000};
        ld_data_o = 32'h0;
        case (ld_size_i)
            SZ_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            SZ_BU:   ld_data_o = {24'h0, shifted[7:0]};
            SZ_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            SZ_HU:   ld_data_o = {16'h0, shifted[15:0]};
            SZ_W:    ld_data_o = ld_word_i;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-banked data memory between fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data always wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e  state_q;
    owner_e      owner_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        if_rvalid_q;
    logic        d_rvalid_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic [3:0]  st_we;
    logic [31:0] st_wdata;
    logic        d_bad;
    logic [31:0] ld_data;

    logic        prefer_d;
    logic        arb_idle;
    logic        d_wins;
    logic        i_wins;
    logic        d_acc;
    logic        d_store;
    logic        addr_unused;

`ifdef MEM_ARB_RR_EN
    owner_e      last_q;
    assign prefer_d = (last_q == OWN_IF);
`else
    assign prefer_d = 1'b1;
`endif

    mem_lane_steer u_steer (
        .size_i     (bus.d_size),
        .off_i      (bus.d_addr[1:0]),
        .wdata_i    (bus.d_wdata),
        .we_o       (st_we),
        .wdata_o    (st_wdata),
        .misalign_o (d_bad),
        .ld_size_i  (size_q),
        .ld_off_i   (off_q),
        .ld_word_i  (bus.mem_rdata),
        .ld_data_o  (ld_data)
    );

    // A rejected data access still counts as the data side winning arbitration.
    assign arb_idle = (state_q == IDLE) && !rst;
    assign d_wins   = arb_idle && bus.d_req && (prefer_d || !bus.if_req);
    assign i_wins   = arb_idle && bus.if_req && !d_wins;
    assign d_acc    = d_wins && !d_bad;
    assign d_store  = d_acc && bus.d_we;

    assign bus.if_gnt    = i_wins;
    assign bus.d_gnt     = d_acc;
    assign bus.d_err     = d_wins && d_bad;
    assign bus.mem_re    = i_wins || (d_acc && !bus.d_we);
    assign bus.mem_we    = d_store ? st_we : 4'b0000;
    assign bus.mem_wdata = d_store ? st_wdata : 32'h0;
    assign bus.mem_addr  = i_wins ? bus.if_addr[ADDR_W+1:2] :
                           d_acc  ? bus.d_addr[ADDR_W+1:2]  : '0;

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;

    assign addr_unused = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                           bus.d_addr[31:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            size_q      <= SZ_B;
            off_q       <= 2'b00;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
`ifdef MEM_ARB_RR_EN
            last_q      <= OWN_IF;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_wins) begin
                        owner_q <= OWN_IF;
                        state_q <= RD;
                    end else if (d_acc && !bus.d_we) begin
                        owner_q <= OWN_D;
                        size_q  <= bus.d_size;
                        off_q   <= bus.d_addr[1:0];
                        state_q <= RD;
                    end
`ifdef MEM_ARB_RR_EN
                    if (i_wins) begin
                        last_q <= OWN_IF;
                    end else if (d_wins) begin
                        last_q <= OWN_D;
                    end
`endif
                end
                RD: begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_q  <= bus.mem_rdata;
                        if_rvalid_q <= 1'b1;
                    end else begin
                        d_rdata_q   <= ld_data;
                        d_rvalid_q  <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if_rvalid_q <= 1'b0;
                    d_rvalid_q  <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, arbitration/reset sequences and a
// randomized run against a byte-level memory model. Honours MEM_ARB_RR_EN.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 20;
    localparam int NV     = 17;

    typedef struct packed {
        logic        isFetch;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] word;
        logic        expIfGnt;
        logic        expDGnt;
        logic        expErr;
        logic        expRe;
        logic [3:0]  expWe;
        logic [31:0] expWdata;
        logic [19:0] expAddr;
        logic [31:0] expRdata;
    } vec_t;

    logic        clk;
    logic        rst;
    int          total;
    int          bad;
    vec_t        vecs [NV];
    logic [31:0] busMem [int];
    logic [7:0]  refMem [int];
    logic [31:0] memTmp;

    int          grants, lastCyc, overlap, outcome, lat, got, kind, nb, sz;
    int          ownerSeq [6];
    int          gapSeq [6];
    logic [31:0] addr, wdata, expv;
    logic [2:0]  size;
    logic        expErr;
    longint      v;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [31:0] memRead(input int key);
        if (busMem.exists(key)) return busMem[key];
        return 32'h0;
    endfunction

    // Synchronous one-cycle memory; data is scrambled on non-read cycles.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= memRead(int'(bus.mem_addr));
        else            bus.mem_rdata <= $urandom;
        if (bus.mem_we != 4'b0000) begin
            memTmp = memRead(int'(bus.mem_addr));
            for (int l = 0; l < 4; l++)
                if (bus.mem_we[l]) memTmp[8*l +: 8] = bus.mem_wdata[8*l +: 8];
            busMem[int'(bus.mem_addr)] = memTmp;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_size  = 3'd0;
        bus.d_wdata = 32'h0;
    endtask

    task automatic toDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic isFetch, input logic we, input logic [31:0] a,
                                 input logic [2:0] s, input logic [31:0] wd);
        idleInputs();
        if (isFetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = a;
        end else begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = a;
            bus.d_size  = s;
            bus.d_wdata = wd;
        end
    endtask

    function automatic int sizeBytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd3: return 1;
            3'd1, 3'd4: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idleInputs();

        //          fetch we  addr          size   wdata         word          ifG dG err re  we       wdata         addr      rdata
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0104, SZ_W,  32'h0,        32'h0041_0113, 1'b1,1'b0,1'b0,1'b1, 4'b0000, 32'h0,        20'h00041, 32'h0041_0113};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0102, SZ_B,  32'h0000_00AB,32'h0,         1'b0,1'b1,1'b0,1'b0, 4'b0100, 32'hABAB_ABAB,20'h00040, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0203, SZ_B,  32'h0,        32'h80FF_0000, 1'b0,1'b1,1'b0,1'b1, 4'b0000, 32'h0,        20'h00080, 32'hFFFF_FF80};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0203, SZ_BU, 32'h0,        32'h80FF_0000, 1'b0,1'b1,1'b0,1'b1, 4'b0000, 32'h0,        20'h00080, 32'h0000_0080};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0101, SZ_H,  32'h0,        32'h0,         1'b0,1'b0,1'b1,1'b0, 4'b0000, 32'h0,        20'h00000, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0302, SZ_H,  32'h1234_BEEF,32'h0,         1'b0,1'b1,1'b0,1'b0, 4'b1100, 32'hBEEF_BEEF,20'h000C0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0402, SZ_H,  32'h0,        32'h8001_7FFF, 1'b0,1'b1,1'b0,1'b1, 4'b0000, 32'h0,        20'h00100, 32'hFFFF_8001};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_0402, SZ_HU, 32'h0,        32'h8001_7FFF, 1'b0,1'b1,1'b0,1'b1, 4'b0000, 32'h0,        20'h00100, 32'h0000_8001};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0400, SZ_HU, 32'h0,        32'h8001_7FFF, 1'b0,1'b1,1'b0,1'b1, 4'b0000, 32'h0,        20'h00100, 32'h0000_7FFF};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0500, SZ_W,  32'h0,        32'hDEAD_BEEF, 1'b0,1'b1,1'b0,1'b1, 4'b0000, 32'h0,        20'h00140, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0502, SZ_W,  32'h0,        32'h0,         1'b0,1'b0,1'b1,1'b0, 4'b0000, 32'h0,        20'h00000, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0600, 3'd5,  32'h0,        32'h0,         1'b0,1'b0,1'b1,1'b0, 4'b0000, 32'h0,        20'h00000, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_0704, SZ_W,  32'hCAFE_F00D,32'h0,         1'b0,1'b1,1'b0,1'b0, 4'b1111, 32'hCAFE_F00D,20'h001C1, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 32'hF040_0007, SZ_W,  32'h0,        32'h0000_0013, 1'b1,1'b0,1'b0,1'b1, 4'b0000, 32'h0,        20'h00001, 32'h0000_0013};
        vecs[14] = '{1'b0, 1'b1, 32'h0000_0101, SZ_H,  32'h0000_1234,32'h0,         1'b0,1'b0,1'b1,1'b0, 4'b0000, 32'h0,        20'h00000, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 32'h0000_0001, SZ_B,  32'h1234_56C3,32'h0,         1'b0,1'b1,1'b0,1'b0, 4'b0010, 32'hC3C3_C3C3,20'h00000, 32'h0};
        vecs[16] = '{1'b0, 1'b1, 32'h0000_0000, SZ_H,  32'hAAAA_5A6B,32'h0,         1'b0,1'b1,1'b0,1'b0, 4'b0011, 32'h5A6B_5A6B,20'h00000, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset if_gnt",    32'(bus.if_gnt),    32'h0);
        checkOutput("reset d_gnt",     32'(bus.d_gnt),     32'h0);
        checkOutput("reset d_err",     32'(bus.d_err),     32'h0);
        checkOutput("reset if_rvalid", 32'(bus.if_rvalid), 32'h0);
        checkOutput("reset d_rvalid",  32'(bus.d_rvalid),  32'h0);
        checkOutput("reset if_rdata",  bus.if_rdata,       32'h0);
        checkOutput("reset d_rdata",   bus.d_rdata,        32'h0);
        checkOutput("reset mem_re",    32'(bus.mem_re),    32'h0);
        checkOutput("reset mem_we",    32'(bus.mem_we),    32'h0);
        checkOutput("reset mem_addr",  32'(bus.mem_addr),  32'h0);
        checkOutput("reset mem_wdata", bus.mem_wdata,      32'h0);
        toDrive();

        // Single requests from the table: grant cycle, then response two cycles later.
        for (int i = 0; i < NV; i++) begin
            busMem[int'((vecs[i].addr >> 2) & 32'h000F_FFFF)] = vecs[i].word;
            applyStimulus(vecs[i].isFetch, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata);
            @(negedge clk);
            checkOutput($sformatf("v%0d if_gnt", i),    32'(bus.if_gnt),   32'(vecs[i].expIfGnt));
            checkOutput($sformatf("v%0d d_gnt", i),     32'(bus.d_gnt),    32'(vecs[i].expDGnt));
            checkOutput($sformatf("v%0d d_err", i),     32'(bus.d_err),    32'(vecs[i].expErr));
            checkOutput($sformatf("v%0d mem_re", i),    32'(bus.mem_re),   32'(vecs[i].expRe));
            checkOutput($sformatf("v%0d mem_we", i),    32'(bus.mem_we),   32'(vecs[i].expWe));
            checkOutput($sformatf("v%0d mem_wdata", i), bus.mem_wdata,     vecs[i].expWdata);
            checkOutput($sformatf("v%0d mem_addr", i),  32'(bus.mem_addr), 32'(vecs[i].expAddr));
            toDrive();
            idleInputs();
            @(negedge clk);
            checkOutput($sformatf("v%0d early rvalid", i), 32'({bus.if_rvalid, bus.d_rvalid, bus.d_err}), 32'h0);
            @(negedge clk);
            if (vecs[i].expRe && vecs[i].isFetch) begin
                checkOutput($sformatf("v%0d if_rvalid", i), 32'({bus.if_rvalid, bus.d_rvalid}), 32'h2);
                checkOutput($sformatf("v%0d if_rdata", i),  bus.if_rdata, vecs[i].expRdata);
            end else if (vecs[i].expRe) begin
                checkOutput($sformatf("v%0d d_rvalid", i), 32'({bus.if_rvalid, bus.d_rvalid}), 32'h1);
                checkOutput($sformatf("v%0d d_rdata", i),  bus.d_rdata, vecs[i].expRdata);
            end else begin
                checkOutput($sformatf("v%0d no rvalid", i), 32'({bus.if_rvalid, bus.d_rvalid}), 32'h0);
            end
            toDrive();
        end

        // Both sides requesting back to back.
        doReset();
        busMem[32'h200] = 32'h0000_0013;
        busMem[32'h201] = 32'h1357_9BDF;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0800;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_size  = SZ_W;
        bus.d_addr  = 32'h0000_0804;
        grants  = 0;
        lastCyc = -3;
        overlap = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (bus.if_gnt && bus.d_gnt) overlap = 1;
            if (bus.if_gnt || bus.d_gnt) begin
                if (grants < 6) begin
                    ownerSeq[grants] = bus.d_gnt ? 1 : 0;
                    gapSeq[grants]   = c - lastCyc;
                end
                grants++;
                lastCyc = c;
            end
            toDrive();
        end
        idleInputs();
        checkOutput("arb grant count", 32'(grants), 32'd6);
        checkOutput("arb double grant", 32'(overlap), 32'd0);
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
            checkOutput($sformatf("arb grant %0d is data", k), 32'(ownerSeq[k]), 32'((k % 2) == 0));
`else
            checkOutput($sformatf("arb grant %0d is data", k), 32'(ownerSeq[k]), 32'd1);
`endif
            checkOutput($sformatf("arb grant %0d spacing", k), 32'(gapSeq[k]), 32'd3);
        end

        // A rejected access moves the round-robin pointer like a grant.
        doReset();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0800;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_size  = SZ_W;
        bus.d_addr  = 32'h0000_0802;
        @(negedge clk);
        checkOutput("err first d_err",  32'(bus.d_err),  32'd1);
        checkOutput("err first if_gnt", 32'(bus.if_gnt), 32'd0);
        toDrive();
        @(negedge clk);
`ifdef MEM_ARB_RR_EN
        checkOutput("err next if_gnt", 32'(bus.if_gnt), 32'd1);
        checkOutput("err next d_err",  32'(bus.d_err),  32'd0);
`else
        checkOutput("err next if_gnt", 32'(bus.if_gnt), 32'd0);
        checkOutput("err next d_err",  32'(bus.d_err),  32'd1);
`endif
        toDrive();
        idleInputs();
        repeat (3) toDrive();

        // Stores are granted on consecutive cycles.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h0000_0810 + 32'(k), SZ_B, 32'h5A + 32'(k));
            @(negedge clk);
            checkOutput($sformatf("store run %0d d_gnt", k),  32'(bus.d_gnt),  32'd1);
            checkOutput($sformatf("store run %0d mem_we", k), 32'(bus.mem_we), 32'd1 << k);
            toDrive();
        end
        idleInputs();

        // Reset during RD drops the read; a later fetch behaves normally.
        busMem[32'h240] = 32'h1111_2222;
        busMem[32'h241] = 32'h3333_4444;
        applyStimulus(1'b1, 1'b0, 32'h0000_0900, SZ_W, 32'h0);
        @(negedge clk);
        checkOutput("rstrd grant", 32'(bus.if_gnt), 32'd1);
        toDrive();
        idleInputs();
        rst = 1'b1;
        toDrive();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstrd rvalid",   32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        checkOutput("rstrd if_rdata", bus.if_rdata, 32'h0);
        checkOutput("rstrd strobes",  32'({bus.mem_re, bus.mem_we, bus.if_gnt, bus.d_gnt, bus.d_err}), 32'd0);
        toDrive();
        @(negedge clk);
        checkOutput("rstrd late rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        toDrive();
        applyStimulus(1'b1, 1'b0, 32'h0000_0900, SZ_W, 32'h0);
        @(negedge clk);
        checkOutput("rstrd refetch grant", 32'(bus.if_gnt), 32'd1);
        toDrive();
        idleInputs();
        toDrive();
        @(negedge clk);
        checkOutput("rstrd refetch rvalid", 32'(bus.if_rvalid), 32'd1);
        checkOutput("rstrd refetch rdata",  bus.if_rdata, 32'h1111_2222);
        toDrive();
        applyStimulus(1'b0, 1'b0, 32'h0000_0904, SZ_W, 32'h0);
        toDrive();
        idleInputs();
        toDrive();
        @(negedge clk);
        checkOutput("hold d_rdata",  bus.d_rdata,  32'h3333_4444);
        checkOutput("hold if_rdata", bus.if_rdata, 32'h1111_2222);
        toDrive();
        @(negedge clk);
        checkOutput("hold d_rdata after", bus.d_rdata, 32'h3333_4444);
        checkOutput("hold rvalid gone", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
        toDrive();

        // Random single transactions against a byte-addressed model.
        doReset();
        for (int w = 0; w < 16; w++) begin
            memTmp = $urandom;
            busMem[32'h200 + w] = memTmp;
            for (int b = 0; b < 4; b++) refMem[32'h800 + 4*w + b] = memTmp[8*b +: 8];
        end
        for (int t = 0; t < 80; t++) begin
            kind  = $urandom_range(0, 2);
            addr  = 32'h0000_0800 + 32'($urandom_range(0, 63));
            wdata = $urandom;
            if (kind == 2) begin
                sz   = $urandom_range(0, 3);
                size = (sz == 3) ? 3'd5 : 3'(sz);
            end else begin
                size = 3'($urandom_range(0, 7));
            end
            nb     = sizeBytes(size);
            expErr = (kind != 0) && ((nb == 0) || ((int'(addr) % nb) != 0));
            applyStimulus(kind == 0, kind == 2, addr, size, wdata);
            outcome = 2;
            for (int w = 0; w < 4 && outcome == 2; w++) begin
                @(negedge clk);
                if ((kind == 0) ? bus.if_gnt : bus.d_gnt) outcome = 0;
                else if (bus.d_err) outcome = 1;
                else toDrive();
            end
            checkOutput($sformatf("rnd%0d outcome", t), 32'(outcome), expErr ? 32'd1 : 32'd0);
            if (outcome == 0)
                checkOutput($sformatf("rnd%0d mem_addr", t), 32'(bus.mem_addr), (addr >> 2) & 32'h000F_FFFF);
            toDrive();
            idleInputs();
            if (outcome == 0 && kind == 2) begin
                for (int b = 0; b < nb; b++) refMem[int'(addr) + b] = wdata[8*b +: 8];
            end
            if (outcome == 0 && kind != 2) begin
                lat = 0;
                got = 0;
                for (int w = 0; w < 4 && got == 0; w++) begin
                    @(negedge clk);
                    lat++;
                    got = ((kind == 0) ? bus.if_rvalid : bus.d_rvalid) ? 1 : 0;
                end
                checkOutput($sformatf("rnd%0d latency", t), 32'(lat), 32'd2);
                v = 0;
                if (kind == 0) begin
                    for (int b = 0; b < 4; b++) v += longint'(refMem[int'(addr & ~32'h3) + b]) << (8*b);
                end else begin
                    for (int b = 0; b < nb; b++) v += longint'(refMem[int'(addr) + b]) << (8*b);
                    if ((size == SZ_B || size == SZ_H) && v >= (longint'(1) << (8*nb - 1)))
                        v -= (longint'(1) << (8*nb));
                end
                expv = v[31:0];
                checkOutput($sformatf("rnd%0d rdata", t), (kind == 0) ? bus.if_rdata : bus.d_rdata, expv);
                toDrive();
            end else begin
                @(negedge clk);
                checkOutput($sformatf("rnd%0d no rvalid", t), 32'({bus.if_rvalid, bus.d_rvalid, bus.d_err}), 32'd0);
                toDrive();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
